// File: rtl/grom_mem_responder.sv
// grom8 bus responder: byte RAM in memory space, port/sync/fetch-counter registers in I/O space.
// Optional write protection of low memory is enabled by defining GROM_MEM_WP_EN.
module grom_mem_responder #(
    parameter int          RAM_AW    = 12,
    parameter string       INIT_FILE = "",
    parameter logic [11:0] WP_TOP    = 12'h0FF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [11:0] addr,
    input  logic [7:0]  data_in,
    output logic [7:0]  data_out,
    input  logic        we,
    input  logic        ioreq,
    input  logic        m1,
    input  logic [7:0]  port_in,
    output logic [7:0]  port_out,
    output logic        wp_fault
);

    localparam int         DEPTH       = 1 << RAM_AW;
    localparam logic [7:0] IO_PORT_OUT = 8'h00;
    localparam logic [7:0] IO_PORT_IN  = 8'h01;
    localparam logic [7:0] IO_CNT_LO   = 8'h02;
    localparam logic [7:0] IO_CNT_HI   = 8'h03;
    localparam logic [7:0] IO_WP       = 8'h04;

    logic [7:0]        mem [DEPTH];
    logic [RAM_AW-1:0] ram_addr;
    logic [7:0]        io_addr;
    logic              io_wr;
    logic              mem_wr_req;
    logic              mem_wr;
    logic              wp_hit;
    logic [7:0]        sync1;
    logic [7:0]        sync2;
    logic [15:0]       fetch_cnt;
    logic [7:0]        cnt_hi_snap;
    logic [7:0]        rd_data;

    // Bus has no handshake: every edge is a complete cycle, reads always answer one edge
    // later and a store is accepted on the single edge where we=1.
    assign ram_addr   = addr[RAM_AW-1:0];
    assign io_addr    = addr[7:0];
    assign io_wr      = we & ioreq;
    assign mem_wr_req = we & ~ioreq;
    assign mem_wr     = mem_wr_req & ~wp_hit;

`ifdef GROM_MEM_WP_EN
    logic wp_fault_q;

    assign wp_hit = mem_wr_req && (32'(ram_addr) <= 32'(WP_TOP));

    // A blocked store and a clear cannot share an edge on this bus, but set wins anyway.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wp_fault_q <= 1'b0;
        end else if (wp_hit) begin
            wp_fault_q <= 1'b1;
        end else if (io_wr && io_addr == IO_WP) begin
            wp_fault_q <= 1'b0;
        end
    end

    assign wp_fault = wp_fault_q;
`else
    logic unused_wp_top;

    assign wp_hit        = 1'b0;
    assign wp_fault      = 1'b0;
    assign unused_wp_top = ^WP_TOP;
`endif

    // Reset in the sensitivity list only so a store on an edge taken in reset is dropped.
    always_ff @(posedge clk or negedge reset) begin
        if (reset && mem_wr) begin
            mem[ram_addr] <= data_in;
        end
    end

    always_comb begin
        rd_data = 8'h00;
        if (ioreq) begin
            case (io_addr)
                IO_PORT_OUT: rd_data = port_out;
                IO_PORT_IN:  rd_data = sync2;
                IO_CNT_LO:   rd_data = fetch_cnt[7:0];
                IO_CNT_HI:   rd_data = cnt_hi_snap;
                IO_WP:       rd_data = {7'b0, wp_fault};
                default:     rd_data = 8'h00;
            endcase
        end else begin
            rd_data = mem[ram_addr];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            data_out    <= 8'h00;
            port_out    <= 8'h00;
            sync1       <= 8'h00;
            sync2       <= 8'h00;
            fetch_cnt   <= 16'h0000;
            cnt_hi_snap <= 8'h00;
        end else begin
            data_out <= rd_data;
            sync1    <= port_in;
            sync2    <= sync1;
            if (io_wr && io_addr == IO_PORT_OUT) begin
                port_out <= data_in;
            end
            if (io_wr && io_addr == IO_CNT_LO) begin
                fetch_cnt <= 16'h0000;
            end else if (m1) begin
                fetch_cnt <= fetch_cnt + 16'd1;
            end
            // High byte frozen on the same edge the low byte is presented.
            if (ioreq && !we && io_addr == IO_CNT_LO) begin
                cnt_hi_snap <= fetch_cnt[15:8];
            end
        end
    end

endmodule

// File: tb/tb_grom_mem_responder.sv
// Bench for grom_mem_responder: directed vector table, multi-cycle corner sequences,
// then random bus traffic checked against a behavioural model of the responder.
module tb_grom_mem_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic [11:0] addr;
    logic [7:0]  data_in;
    logic [7:0]  data_out;
    logic        we;
    logic        ioreq;
    logic        m1;
    logic [7:0]  port_in;
    logic [7:0]  port_out;
    logic        wp_fault;

`ifdef GROM_MEM_WP_EN
    localparam bit WP_ON = 1'b1;
`else
    localparam bit WP_ON = 1'b0;
`endif

    always #5 clk = ~clk;

    grom_mem_responder dut (
        .clk      (clk),
        .reset    (reset),
        .addr     (addr),
        .data_in  (data_in),
        .data_out (data_out),
        .we       (we),
        .ioreq    (ioreq),
        .m1       (m1),
        .port_in  (port_in),
        .port_out (port_out),
        .wp_fault (wp_fault)
    );

    int n_vec = 0;
    int n_bad = 0;

    // Behavioural model: RAM as a sparse map, counter as a plain integer mod 65536.
    logic [7:0] m_ram [int];
    logic [7:0] m_port;
    logic [7:0] m_snap;
    int         m_fetch;
    logic       m_wp;
    logic [7:0] m_pin_hist [$];
    logic [7:0] exp_dout;
    logic       exp_known;

    function automatic void model_reset();
        m_port     = 8'h00;
        m_snap     = 8'h00;
        m_fetch    = 0;
        m_wp       = 1'b0;
        m_pin_hist = '{8'h00, 8'h00};
    endfunction

    function automatic void model_edge();
        int         ra;
        logic [7:0] ia;
        bit         set_wp;
        ra        = int'(addr);
        ia        = addr[7:0];
        set_wp    = 1'b0;
        exp_known = 1'b1;
        exp_dout  = 8'h00;
        if (ioreq) begin
            case (ia)
                8'h00:   exp_dout = m_port;
                8'h01:   exp_dout = m_pin_hist[1];
                8'h02:   exp_dout = 8'(m_fetch % 256);
                8'h03:   exp_dout = m_snap;
                8'h04:   exp_dout = {7'b0, m_wp};
                default: exp_dout = 8'h00;
            endcase
        end else if (m_ram.exists(ra)) begin
            exp_dout = m_ram[ra];
        end else begin
            exp_known = 1'b0;
        end
        if (ioreq && !we && ia == 8'h02) m_snap = 8'(m_fetch / 256);
        if (we && ioreq && ia == 8'h00) m_port = data_in;
        if (we && ioreq && ia == 8'h02) m_fetch = 0;
        else if (m1) m_fetch = (m_fetch + 1) % 65536;
        if (we && !ioreq) begin
            if (WP_ON && ra <= 'h0FF) set_wp = 1'b1;
            else m_ram[ra] = data_in;
        end
        if (set_wp) m_wp = 1'b1;
        else if (we && ioreq && ia == 8'h04) m_wp = 1'b0;
        m_pin_hist.push_front(port_in);
        void'(m_pin_hist.pop_back());
    endfunction

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [11:0] a, input logic [7:0] d, input logic w,
                         input logic io, input logic m);
        addr    = a;
        data_in = d;
        we      = w;
        ioreq   = io;
        m1      = m;
    endtask

    task automatic cmp8(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic [11:0] addr;
        logic [7:0]  din;
        logic        we;
        logic        io;
        logic        chk;
        logic [7:0]  dout;
        logic [7:0]  port;
    } vec_t;

    vec_t vt [13];

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // addr, din, we, io, chk, dout, port
        vt[0]  = '{12'h002, 8'h00, 1'b0, 1'b1, 1'b1, 8'h00, 8'h00};
        vt[1]  = '{12'h345, 8'h5A, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00};
        vt[2]  = '{12'h345, 8'h00, 1'b0, 1'b0, 1'b1, 8'h5A, 8'h00};
        vt[3]  = '{12'h345, 8'h11, 1'b1, 1'b0, 1'b1, 8'h5A, 8'h00};
        vt[4]  = '{12'h345, 8'h00, 1'b0, 1'b0, 1'b1, 8'h11, 8'h00};
        vt[5]  = '{12'h000, 8'hC3, 1'b1, 1'b1, 1'b1, 8'h00, 8'hC3};
        vt[6]  = '{12'h000, 8'h00, 1'b0, 1'b1, 1'b1, 8'hC3, 8'hC3};
        vt[7]  = '{12'h104, 8'h00, 1'b0, 1'b1, 1'b1, 8'h00, 8'hC3};
        vt[8]  = '{12'h005, 8'hFF, 1'b1, 1'b1, 1'b1, 8'h00, 8'hC3};
        vt[9]  = '{12'h100, 8'h00, 1'b0, 1'b1, 1'b1, 8'hC3, 8'hC3};
        vt[10] = '{12'h3FF, 8'hA5, 1'b1, 1'b0, 1'b0, 8'h00, 8'hC3};
        vt[11] = '{12'h3FF, 8'h00, 1'b0, 1'b0, 1'b1, 8'hA5, 8'hC3};
        vt[12] = '{12'h345, 8'h00, 1'b0, 1'b0, 1'b1, 8'h11, 8'hC3};

        // Reset held for three edges.
        reset   = 1'b0;
        port_in = 8'h00;
        drive(12'h000, 8'h00, 1'b0, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        cmp8("rst_data_out", data_out, 8'h00);
        cmp8("rst_port_out", port_out, 8'h00);
        cmp8("rst_wp_fault", {7'b0, wp_fault}, 8'h00);
        model_reset();
        reset = 1'b1;

        for (int i = 0; i < 13; i++) begin
            drive(vt[i].addr, vt[i].din, vt[i].we, vt[i].io, 1'b0);
            tick();
            if (vt[i].chk) cmp8($sformatf("vec%0d_dout", i), data_out, vt[i].dout);
            cmp8($sformatf("vec%0d_port", i), port_out, vt[i].port);
            cmp8($sformatf("vec%0d_wp", i), {7'b0, wp_fault}, 8'h00);
        end

        // Input pin through the synchroniser: visible on the third edge.
        port_in = 8'h81;
        drive(12'h001, 8'h00, 1'b0, 1'b1, 1'b0);
        tick();
        cmp8("sync_early", data_out, 8'h00);
        tick();
        tick();
        cmp8("sync_in", data_out, 8'h81);

        // Fetch counter: 300 fetches, coherent read, clear vs m1, full wrap.
        repeat (300) begin
            drive(12'h005, 8'h00, 1'b0, 1'b1, 1'b1);
            tick();
        end
        drive(12'h002, 8'h00, 1'b0, 1'b1, 1'b0);
        tick();
        cmp8("cnt_lo_300", data_out, 8'h2C);
        drive(12'h003, 8'h00, 1'b0, 1'b1, 1'b0);
        tick();
        cmp8("cnt_hi_300", data_out, 8'h01);
        drive(12'h002, 8'h99, 1'b1, 1'b1, 1'b1);
        tick();
        drive(12'h002, 8'h00, 1'b0, 1'b1, 1'b0);
        tick();
        cmp8("cnt_clr_wins", data_out, 8'h00);
        repeat (65536) begin
            drive(12'h005, 8'h00, 1'b0, 1'b1, 1'b1);
            tick();
        end
        drive(12'h002, 8'h00, 1'b0, 1'b1, 1'b0);
        tick();
        cmp8("cnt_wrap_lo", data_out, 8'h00);
        drive(12'h003, 8'h00, 1'b0, 1'b1, 1'b0);
        tick();
        cmp8("cnt_wrap_hi", data_out, 8'h00);

        // Write protection boundary around 12'h0FF/12'h100.
        drive(12'h080, 8'h77, 1'b1, 1'b0, 1'b0);
        tick();
`ifdef GROM_MEM_WP_EN
        cmp8("wp_set", {7'b0, wp_fault}, 8'h01);
`else
        cmp8("wp_set", {7'b0, wp_fault}, 8'h00);
`endif
        drive(12'h080, 8'h00, 1'b0, 1'b0, 1'b0);
        tick();
`ifndef GROM_MEM_WP_EN
        cmp8("wp_rd080", data_out, 8'h77);
`endif
        drive(12'h100, 8'h66, 1'b1, 1'b0, 1'b0);
        tick();
        drive(12'h100, 8'h00, 1'b0, 1'b0, 1'b0);
        tick();
        cmp8("wp_rd100", data_out, 8'h66);
        drive(12'h004, 8'h00, 1'b1, 1'b1, 1'b0);
        tick();
        cmp8("wp_clr", {7'b0, wp_fault}, 8'h00);
        drive(12'h004, 8'h00, 1'b0, 1'b1, 1'b0);
        tick();
        cmp8("wp_rd_io4", data_out, 8'h00);

        // Reset asserted mid-cycle during a store.
        drive(12'h010, 8'h3C, 1'b1, 1'b0, 1'b0);
        tick();
        drive(12'h000, 8'h99, 1'b1, 1'b1, 1'b0);
        tick();
        cmp8("pre_rst_port", port_out, 8'h99);
        drive(12'h010, 8'hEE, 1'b1, 1'b0, 1'b0);
        #2 reset = 1'b0;
        #1;
        cmp8("midrst_dout", data_out, 8'h00);
        cmp8("midrst_port", port_out, 8'h00);
        cmp8("midrst_wp", {7'b0, wp_fault}, 8'h00);
        @(posedge clk);
        #1;
        model_reset();
        reset = 1'b1;
        drive(12'h010, 8'h00, 1'b0, 1'b0, 1'b0);
        tick();
        if (exp_known) cmp8("midrst_ram010", data_out, exp_dout);
        drive(12'h000, 8'h55, 1'b1, 1'b1, 1'b0);
        #2 reset = 1'b0;
        @(posedge clk);
        #1;
        model_reset();
        reset = 1'b1;
        drive(12'h000, 8'h00, 1'b0, 1'b1, 1'b0);
        tick();
        cmp8("midrst_io_dout", data_out, 8'h00);
        cmp8("midrst_io_port", port_out, 8'h00);

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            logic [11:0] a;
            logic        io;
            io = 1'($urandom_range(0, 1));
            if (io) a = {($urandom_range(0, 1) != 0) ? 4'h3 : 4'h0, 8'($urandom_range(0, 6))};
            else if ($urandom_range(0, 1) != 0) a = 12'h0F8 + 12'($urandom_range(0, 15));
            else a = 12'h340 + 12'($urandom_range(0, 15));
            if ($urandom_range(0, 7) == 0) port_in = 8'($urandom);
            drive(a, 8'($urandom), $urandom_range(0, 3) == 0, io, 1'($urandom_range(0, 1)));
            tick();
            if (exp_known) cmp8("rnd_dout", data_out, exp_dout);
            cmp8("rnd_port", port_out, m_port);
            cmp8("rnd_wp", {7'b0, wp_fault}, {7'b0, m_wp});
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
